// File: rtl/serial_defs_pkg.sv
// -----------------------------------------------------------------------------
// serial_defs_pkg
//   Definitions shared by the serial/parallel block set (this PISO transmitter
//   and the matching SIPO receiver): the FSM state encoding, the default word
//   width, and a helper that sizes the per-frame bit counter.
// -----------------------------------------------------------------------------
package serial_defs_pkg;

   // Default word width used by both ends of the serial link.
   localparam int unsigned SERIAL_WIDTH_DEFAULT = 4;

   // Two-state framing FSM: IDLE drives an idle line, SHIFT emits frame bits.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   // Counter width able to hold 0..width-1; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage : serial_defs_pkg

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx
//   Parallel-in serial-out transmitter. A WIDTH-bit word is taken through a
//   valid/ready handshake and shifted out one bit per clock, with a bit-valid
//   strobe and start/end-of-frame markers. A new word may be accepted in the
//   cycle that the last bit of the current frame is being sent, so words
//   offered back-to-back go out with no idle cycle between frames.
//
// Parameters
//   WIDTH      word length in bits, legal range 2..32
//   MSB_FIRST  1: din[WIDTH-1] is sent first; 0: din[0] is sent first
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   din         parallel word, sampled only when a word is accepted
//   load_valid  producer offers a word on din
//   load_ready  block accepts a word this cycle (combinational from state)
//   dout        serial data bit (registered)
//   dout_valid  dout carries a frame bit (registered)
//   sof         first bit of a frame (registered)
//   eof         last bit of a frame (registered)
// -----------------------------------------------------------------------------
module piso_tx
   import serial_defs_pkg::*;
#(
   parameter int unsigned WIDTH     = SERIAL_WIDTH_DEFAULT,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             sof,
   output logic             eof
);

   localparam int unsigned          CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   ser_state_e        state_q,      state_d;
   logic [WIDTH-1:0]  shreg_q,      shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
   logic              dout_q,       dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              sof_q,        sof_d;
   logic              eof_q,        eof_d;

   logic              last_bit;
   logic              accept;
   logic              cur_bit;
   logic [WIDTH-1:0]  shreg_shifted;

   // The last bit of a frame is the slot where the next word can be loaded;
   // this is what makes back-to-back frames seamless.
   assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
   assign load_ready = reset && ((state_q == IDLE) || last_bit);
   assign accept     = load_valid && load_ready;

   // Bit presented this cycle and the register after moving it out; the
   // vacated end fills with zero.
   always_comb begin
      if (MSB_FIRST) begin
         cur_bit       = shreg_q[WIDTH-1];
         shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
         cur_bit       = shreg_q[0];
         shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned; an unassigned path in always_comb infers a latch.
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      dout_d       = 1'b0;
      dout_valid_d = 1'b0;
      sof_d        = 1'b0;
      eof_d        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d   = din;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            dout_d       = cur_bit;
            dout_valid_d = 1'b1;
            sof_d        = (bit_cnt_q == '0);
            eof_d        = last_bit;

            if (last_bit) begin
               // Counter is reloaded or the frame ends here, so it never wraps.
               bit_cnt_d = '0;
               if (accept) begin
                  shreg_d = din;
               end else begin
                  shreg_d = shreg_shifted;
                  state_d = IDLE;
               end
            end else begin
               shreg_d   = shreg_shifted;
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of statement order.
   // NOTE: the shift register is cleared on reset too, so an aborted frame
   // leaves no stale data behind.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         sof_q        <= 1'b0;
         eof_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         sof_q        <= sof_d;
         eof_q        <= eof_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign sof        = sof_q;
   assign eof        = eof_q;

endmodule : piso_tx
